peripheral_axi4_read_burst_master: RTL and testbench
====================================================

Name: peripheral_axi4_read_burst_master

Overview:
Parametrised AXI4 read master. It converts a simple core-side burst request (address, beat count) into one AXI4 INCR read burst and buffers the returned R beats in an internal FIFO. Beats are delivered to the consumer over a valid/ready stream. It generalises the fixed 64-bit AXI address/data widths to configurable address, data and ID widths, and adds credit-based flow control, 4KB-boundary checking, alignment checking and response-error reporting.

Parameters:
AXI_ADDR_WIDTH, 64, address width
AXI_DATA_WIDTH, 64, data width (power of two, 32..1024)
AXI_ID_WIDTH, 4, ID width
AXI_ID, 0, constant ID driven on AR
MAX_LEN, 16, max beats per burst (1..256)
FIFO_DEPTH, 16, R-beat buffer entries (power of two, >= MAX_LEN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  burst request valid
req_ready  out  1  request accepted when high with req_valid
req_addr  in  AXI_ADDR_WIDTH  start byte address
req_len  in  8  beats minus one
axi_ar_id  out  AXI_ID_WIDTH  AR ID (=AXI_ID)
axi_ar_addr  out  AXI_ADDR_WIDTH  AR address
axi_ar_len  out  8  AR length
axi_ar_size  out  3  log2(AXI_DATA_WIDTH/8)
axi_ar_burst  out  2  always INCR (2'b01)
axi_ar_valid  out  1  AR valid
axi_ar_ready  in  1  AR ready
axi_r_id  in  AXI_ID_WIDTH  R ID (ignored)
axi_r_data  in  AXI_DATA_WIDTH  R data
axi_r_resp  in  2  R response
axi_r_last  in  1  R last
axi_r_valid  in  1  R valid
axi_r_ready  out  1  R ready
rd_valid  out  1  buffered beat available
rd_ready  in  1  consumer accepts beat
rd_data  out  AXI_DATA_WIDTH  beat data
rd_last  out  1  final beat of the request
rd_err  out  1  beat carries an error
busy  out  1  state != IDLE

Behaviour:
- Reset (rst sampled high at a clk edge): state IDLE, FIFO emptied, beat counter 0. All outputs 0 except the constant outputs axi_ar_id, axi_ar_size and axi_ar_burst. Reset mid-burst abandons the burst; the interconnect/slave must be reset together with this block.
- FSM states: IDLE, AR, DATA, ERR.
- IDLE:
  - req_ready = (free_entries >= req_len+1). free_entries counts pops in the same cycle only from the next cycle on.
  - On acceptance, the request is checked. Illegal if req_len+1 > MAX_LEN, if req_addr is not aligned to the bus width, or if addr + (len+1)*bytes crosses a 4KB boundary.
  - Illegal request -> ERR. Legal request -> AR, with axi_ar_addr and axi_ar_len registered.
- AR: axi_ar_valid=1 and stays stable until axi_ar_ready; on the handshake -> DATA. Latency from request handshake to axi_ar_valid: 1 cycle.
- DATA:
  - axi_r_ready=1; overflow is impossible by credit.
  - Each R handshake pushes {data, err, last} and increments the beat counter.
  - err = axi_r_resp[1] (SLVERR/DECERR), OR'd with a length mismatch.
  - The burst ends on axi_r_last or when count==axi_ar_len, whichever comes first. If the two do not coincide, that beat gets err=1. The ending beat has last=1; then -> IDLE with count cleared.
  - Beats after an early end are not expected; behaviour on them is unspecified, and protocol assertions flag them.
- ERR: push one entry {data=0, err=1, last=1}, no AR issued, -> IDLE next cycle.
- FIFO:
  - rd_valid = !empty; head entry drives rd_data/rd_last/rd_err.
  - A beat pushed at cycle N is visible at N+1.
  - Simultaneous push and pop is allowed at any occupancy, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- busy=1 whenever state != IDLE. The FIFO may still hold data while idle.
- Only one burst is outstanding at a time; no new request is accepted until DATA ends.

Decomposition:
- Shared package peripheral_axi4_verilog_pkg gains:
  - AXI_ID_WIDTH default
  - burst encodings (FIXED/INCR/WRAP)
  - resp codes (OKAY/EXOKAY/SLVERR/DECERR)
  - a state enum typedef for this FSM
  - a size-from-width constant function
- One sub-module: peripheral_axi4_sync_fifo (parametrised width/depth, push/pop, full/empty, free count), reusable by a future write master.

Test Plan:
- Legal burst: req_addr=0x1000, req_len=3, slave returns 4 OKAY beats 0xA0..0xA3 with last on beat 3 -> AR addr 0x1000 len 3 size 3 burst 1. rd yields A0..A3, rd_last only on A3, rd_err=0.
- Error response: same burst, beat 1 resp=2'b10 -> only beat 1 has rd_err=1; burst completes normally.
- 4KB crossing: req_addr=0x0FF8, req_len=1 -> no AR issued; one rd entry with data 0, rd_err=1, rd_last=1.
- Credit backpressure: FIFO_DEPTH=16, rd_ready=0, req_len=15 completes, then a second req_len=0 -> req_ready stays 0. One rd pop -> req_ready=1 the next cycle.
- Early last: req_len=3, slave asserts r_last on beat 1 -> beat 1 has rd_err=1 and rd_last=1; FSM returns to IDLE.
- Reset mid-burst: rst high during DATA after 2 beats -> next cycle rd_valid=0, busy=0, axi_ar_valid=0, axi_r_ready=0.

Source files
------------

// File: rtl/peripheral_axi4_verilog_pkg.sv
// Shared AXI4 definitions for the peripheral read/write masters.
package peripheral_axi4_verilog_pkg;

    localparam int AXI_ID_WIDTH_DEFAULT = 4;

    // AxBURST encodings
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // xRESP encodings; bit 1 set means the beat failed
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Read master FSM states
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_AR   = 2'd1,
        RD_DATA = 2'd2,
        RD_ERR  = 2'd3
    } rd_state_e;

    // AxSIZE for a bus of data_width bits: log2(bytes per beat)
    function automatic logic [2:0] axi_size_from_width(input int data_width);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == (data_width / 8)) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/peripheral_axi4_sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty and a free-entry count.
// Push and pop may happen together at any occupancy; a push while full is
// only taken when a pop frees the head slot in the same cycle.
module peripheral_axi4_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    free_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign free_count = CW'(DEPTH) - count;
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign pop_data   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/peripheral_axi4_read_burst_master.sv
// AXI4 read master: one core request becomes one INCR burst whose beats are
// buffered and streamed to the consumer. A request is only accepted when the
// buffer has room for every beat it can return, so R never needs backpressure.
//
// Handshake rule on every channel (req, AR, R, rd): a transfer happens on a
// rising clk edge where valid and ready are both high; a valid source holds
// its payload stable until that edge.
module peripheral_axi4_read_burst_master
    import peripheral_axi4_verilog_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = AXI_ID_WIDTH_DEFAULT,
    parameter int AXI_ID         = 0,
    parameter int MAX_LEN        = 16,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]                req_len,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic [7:0]                axi_ar_len,
    output logic [2:0]                axi_ar_size,
    output logic [1:0]                axi_ar_burst,
    output logic                      axi_ar_valid,
    input  logic                      axi_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_last,
    input  logic                      axi_r_valid,
    output logic                      axi_r_ready,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [AXI_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_last,
    output logic                      rd_err,
    output logic                      busy
);

    localparam int         BYTES  = AXI_DATA_WIDTH / 8;
    localparam logic [2:0] SIZE   = axi_size_from_width(AXI_DATA_WIDTH);
    localparam int         FREE_W = $clog2(FIFO_DEPTH) + 1;
    localparam int         CMP_W  = (FREE_W > 9) ? FREE_W : 9;
    localparam int         FW     = AXI_DATA_WIDTH + 2;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

    rd_state_e         state;
    logic [7:0]        beat_cnt;
    logic              r_ready_q;

    logic [FREE_W-1:0] free_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic [FW-1:0]     push_entry;
    logic [FW-1:0]     head_entry;

    logic [8:0]        need;
    logic              credit_ok;
    logic [16:0]       span_end;
    logic              illegal;
    logic              r_fire;
    logic              count_hit;
    logic              burst_end;
    logic              unused_ok;

    assign axi_ar_id    = AXI_ID_WIDTH'(AXI_ID);
    assign axi_ar_size  = SIZE;
    assign axi_ar_burst = AXI_BURST_INCR;
    assign busy         = (state != RD_IDLE);
    assign unused_ok    = ^{axi_r_id, axi_r_resp[0]};

    // Credit: the whole burst must fit in the buffer before it is requested
    assign need      = {1'b0, req_len} + 9'd1;
    assign credit_ok = CMP_W'(free_cnt) >= CMP_W'(need);
    assign req_ready = (state == RD_IDLE) && req_valid && credit_ok;

    // Request legality: length, bus alignment and 4KB page containment
    assign span_end = {5'b0, req_addr[11:0]} + (17'(need) << SIZE);
    assign illegal  = (need > 9'(MAX_LEN))
                    || ((req_addr & ADDR_MASK) != '0)
                    || (span_end > 17'd4096);

    // Full can only occur if credit was violated; gating keeps it lossless
    assign axi_r_ready = r_ready_q && !fifo_full;
    assign r_fire      = axi_r_valid && axi_r_ready;
    assign count_hit   = (beat_cnt == axi_ar_len);
    assign burst_end   = axi_r_last || count_hit;

    // Buffer entry selection: error token in ERR, R beats in DATA
    always_comb begin
        fifo_push  = 1'b0;
        push_entry = '0;
        if (state == RD_ERR) begin
            fifo_push  = 1'b1;
            push_entry = {{AXI_DATA_WIDTH{1'b0}}, 1'b1, 1'b1};
        end else if (r_fire) begin
            fifo_push  = 1'b1;
            push_entry = {axi_r_data,
                          axi_r_resp[1] | (axi_r_last ^ count_hit),
                          burst_end};
        end
    end

    // Burst sequencing with registered AR and R-ready outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RD_IDLE;
            axi_ar_valid <= 1'b0;
            axi_ar_addr  <= '0;
            axi_ar_len   <= '0;
            r_ready_q    <= 1'b0;
            beat_cnt     <= '0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (req_ready) begin
                        if (illegal) begin
                            state <= RD_ERR;
                        end else begin
                            state        <= RD_AR;
                            axi_ar_valid <= 1'b1;
                            axi_ar_addr  <= req_addr;
                            axi_ar_len   <= req_len;
                        end
                    end
                end
                RD_AR: begin
                    if (axi_ar_ready) begin
                        axi_ar_valid <= 1'b0;
                        r_ready_q    <= 1'b1;
                        state        <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_fire) begin
                        if (burst_end) begin
                            r_ready_q <= 1'b0;
                            beat_cnt  <= '0;
                            state     <= RD_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                RD_ERR: begin
                    state <= RD_IDLE;
                end
                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

    peripheral_axi4_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (push_entry),
        .pop        (rd_ready),
        .pop_data   (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .free_count (free_cnt)
    );

    // Head entry is masked while empty so the outputs read 0 without data
    assign rd_valid = !fifo_empty;
    assign {rd_data, rd_err, rd_last} = fifo_empty ? '0 : head_entry;

endmodule

// File: tb/tb_peripheral_axi4_read_burst_master.sv
// Directed bench for the AXI4 read burst master.
module tb_peripheral_axi4_read_burst_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic [3:0]  axi_ar_id;
    logic [63:0] axi_ar_addr;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size;
    logic [1:0]  axi_ar_burst;
    logic        axi_ar_valid;
    logic        axi_ar_ready;
    logic [3:0]  axi_r_id;
    logic [63:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic        axi_r_last;
    logic        axi_r_valid;
    logic        axi_r_ready;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic        rd_last;
    logic        rd_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    peripheral_axi4_read_burst_master #(
        .AXI_ADDR_WIDTH (64),
        .AXI_DATA_WIDTH (64),
        .AXI_ID_WIDTH   (4),
        .AXI_ID         (0),
        .MAX_LEN        (16),
        .FIFO_DEPTH     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .axi_ar_id    (axi_ar_id),
        .axi_ar_addr  (axi_ar_addr),
        .axi_ar_len   (axi_ar_len),
        .axi_ar_size  (axi_ar_size),
        .axi_ar_burst (axi_ar_burst),
        .axi_ar_valid (axi_ar_valid),
        .axi_ar_ready (axi_ar_ready),
        .axi_r_id     (axi_r_id),
        .axi_r_data   (axi_r_data),
        .axi_r_resp   (axi_r_resp),
        .axi_r_last   (axi_r_last),
        .axi_r_valid  (axi_r_valid),
        .axi_r_ready  (axi_r_ready),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .rd_err       (rd_err),
        .busy         (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------

    task automatic send_req(input logic [63:0] addr, input logic [7:0] len);
        bit ok;
        ok = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (req_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req_handshake: req_ready got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic ar_accept(output logic [63:0] addr, output logic [7:0] len,
                             output logic [2:0] size, output logic [1:0] burst,
                             output logic [3:0] id);
        bit ok;
        ok = 0;
        addr = '0; len = '0; size = '0; burst = '0; id = '0;
        for (int i = 0; i < 50; i++) begin
            if (axi_ar_valid) begin
                ok = 1;
                addr = axi_ar_addr; len = axi_ar_len; size = axi_ar_size;
                burst = axi_ar_burst; id = axi_ar_id;
                axi_ar_ready = 1'b1;
                @(negedge clk);
                axi_ar_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ar_wait: axi_ar_valid got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [1:0] resp,
                             input logic last);
        bit ok;
        ok = 0;
        axi_r_valid = 1'b1;
        axi_r_data  = data;
        axi_r_resp  = resp;
        axi_r_last  = last;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (axi_r_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        axi_r_valid = 1'b0;
        axi_r_last  = 1'b0;
        axi_r_resp  = 2'b00;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL r_wait: axi_r_ready got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic pop_beat(output logic [63:0] data, output logic last,
                            output logic err);
        bit ok;
        ok = 0;
        data = '0; last = 1'b0; err = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rd_valid) begin
                ok = 1;
                data = rd_data; last = rd_last; err = rd_err;
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rd_wait: rd_valid got 0 expected 1 within 50 cycles");
        end
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_addr = '0; req_len = '0;
        axi_ar_ready = 0; axi_r_id = '0; axi_r_data = '0; axi_r_resp = '0;
        axi_r_last = 0; axi_r_valid = 0; rd_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (axi_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid: got %b expected 0", axi_ar_valid); end
        checks++; if (axi_r_ready !== 1'b0) begin errors++; $display("FAIL reset_r_ready: got %b expected 0", axi_r_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({rd_data, rd_last, rd_err} !== 66'd0) begin errors++; $display("FAIL reset_rd_outputs: got %h expected 0", {rd_data, rd_last, rd_err}); end
        checks++; if (axi_ar_id !== 4'd0) begin errors++; $display("FAIL reset_ar_id: got %0d expected 0", axi_ar_id); end
        checks++; if (axi_ar_size !== 3'd3) begin errors++; $display("FAIL reset_ar_size: got %0d expected 3", axi_ar_size); end
        checks++; if (axi_ar_burst !== 2'b01) begin errors++; $display("FAIL reset_ar_burst: got %0d expected 1", axi_ar_burst); end
    endtask

    // Four-beat burst; err_beat selects the beat answered with SLVERR (-1 none)
    task automatic run_four_beat(input logic [63:0] base, input int err_beat, input string tag);
        logic [63:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [3:0] id;
        logic [63:0] d; logic lst; logic e;
        send_req(64'h1000, 8'd3);
        checks++; if (axi_ar_valid !== 1'b1) begin errors++; $display("FAIL %s_ar_latency: ar_valid got %b expected 1", tag, axi_ar_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", tag, busy); end
        ar_accept(a, l, s, b, id);
        checks++; if (a !== 64'h1000) begin errors++; $display("FAIL %s_ar_addr: got %h expected 1000", tag, a); end
        checks++; if (l !== 8'd3) begin errors++; $display("FAIL %s_ar_len: got %0d expected 3", tag, l); end
        checks++; if (s !== 3'd3 || b !== 2'b01 || id !== 4'd0) begin errors++; $display("FAIL %s_ar_attr: size/burst/id got %0d/%0d/%0d expected 3/1/0", tag, s, b, id); end
        for (int i = 0; i < 4; i++)
            send_beat(base + 64'(i), (i == err_beat) ? 2'b10 : 2'b00, i == 3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy got %b expected 0", tag, busy); end
        for (int i = 0; i < 4; i++) begin
            pop_beat(d, lst, e);
            checks++; if (d !== base + 64'(i)) begin errors++; $display("FAIL %s_data%0d: got %h expected %h", tag, i, d, base + 64'(i)); end
            checks++; if (lst !== (i == 3)) begin errors++; $display("FAIL %s_last%0d: got %b expected %b", tag, i, lst, i == 3); end
            checks++; if (e !== (i == err_beat)) begin errors++; $display("FAIL %s_err%0d: got %b expected %b", tag, i, e, i == err_beat); end
        end
    endtask

    task automatic test_legal_burst();
        run_four_beat(64'hA0, -1, "legal");
    endtask

    task automatic test_error_resp();
        run_four_beat(64'hA0, 1, "slverr");
    endtask

    task automatic test_illegal_requests();
        logic [63:0] d; logic lst; logic e;
        logic [63:0] addrs [2];
        logic [7:0]  lens [2];
        addrs[0] = 64'h0FF8; lens[0] = 8'd1;   // crosses 4KB page
        addrs[1] = 64'h1004; lens[1] = 8'd0;   // not 8-byte aligned
        for (int k = 0; k < 2; k++) begin
            send_req(addrs[k], lens[k]);
            checks++; if (busy !== 1'b1 || axi_ar_valid !== 1'b0) begin errors++; $display("FAIL illegal%0d_err_state: busy/ar_valid got %b/%b expected 1/0", k, busy, axi_ar_valid); end
            @(negedge clk);
            checks++; if (busy !== 1'b0 || axi_ar_valid !== 1'b0) begin errors++; $display("FAIL illegal%0d_back_idle: busy/ar_valid got %b/%b expected 0/0", k, busy, axi_ar_valid); end
            pop_beat(d, lst, e);
            checks++; if ({d, lst, e} !== {64'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL illegal%0d_entry: data/last/err got %h/%b/%b expected 0/1/1", k, d, lst, e); end
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL illegal_drained: rd_valid got %b expected 0", rd_valid); end
    endtask

    task automatic test_early_last();
        logic [63:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [3:0] id;
        logic [63:0] d; logic lst; logic e;
        send_req(64'h1000, 8'd3);
        ar_accept(a, l, s, b, id);
        send_beat(64'hB0, 2'b00, 1'b0);
        send_beat(64'hB1, 2'b00, 1'b1);
        checks++; if (busy !== 1'b0 || axi_r_ready !== 1'b0) begin errors++; $display("FAIL early_idle: busy/r_ready got %b/%b expected 0/0", busy, axi_r_ready); end
        pop_beat(d, lst, e);
        checks++; if ({d, lst, e} !== {64'hB0, 1'b0, 1'b0}) begin errors++; $display("FAIL early_beat0: data/last/err got %h/%b/%b expected b0/0/0", d, lst, e); end
        pop_beat(d, lst, e);
        checks++; if ({d, lst, e} !== {64'hB1, 1'b1, 1'b1}) begin errors++; $display("FAIL early_beat1: data/last/err got %h/%b/%b expected b1/1/1", d, lst, e); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL early_drained: rd_valid got %b expected 0", rd_valid); end
    endtask

    task automatic test_credit_backpressure();
        logic [63:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [3:0] id;
        logic [63:0] d; logic lst; logic e;
        rd_ready = 1'b0;
        send_req(64'h2000, 8'd15);
        ar_accept(a, l, s, b, id);
        checks++; if (l !== 8'd15) begin errors++; $display("FAIL credit_ar_len: got %0d expected 15", l); end
        for (int i = 0; i < 16; i++)
            send_beat(64'h100 + 64'(i), 2'b00, i == 15);
        // FIFO now full: a one-beat request must be held off
        req_valid = 1'b1; req_addr = 64'h3000; req_len = 8'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL credit_hold%0d: req_ready got %b expected 0", i, req_ready); end
            @(negedge clk);
        end
        rd_ready = 1'b1;
        #1;
        checks++; if (rd_data !== 64'h100) begin errors++; $display("FAIL credit_head: rd_data got %h expected 100", rd_data); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL credit_same_cycle: req_ready got %b expected 0", req_ready); end
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL credit_release: req_ready got %b expected 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        ar_accept(a, l, s, b, id);
        checks++; if (a !== 64'h3000 || l !== 8'd0) begin errors++; $display("FAIL credit_second_ar: addr/len got %h/%0d expected 3000/0", a, l); end
        send_beat(64'hCC, 2'b00, 1'b1);
        for (int i = 1; i < 16; i++) begin
            pop_beat(d, lst, e);
            checks++; if ({d, lst, e} !== {64'h100 + 64'(i), i == 15, 1'b0}) begin errors++; $display("FAIL credit_drain%0d: data/last/err got %h/%b/%b expected %h/%b/0", i, d, lst, e, 64'h100 + 64'(i), i == 15); end
        end
        pop_beat(d, lst, e);
        checks++; if ({d, lst, e} !== {64'hCC, 1'b1, 1'b0}) begin errors++; $display("FAIL credit_second_beat: data/last/err got %h/%b/%b expected cc/1/0", d, lst, e); end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [3:0] id;
        send_req(64'h4000, 8'd3);
        ar_accept(a, l, s, b, id);
        send_beat(64'hD0, 2'b00, 1'b0);
        send_beat(64'hD1, 2'b00, 1'b0);
        checks++; if (rd_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_before: rd_valid/busy got %b/%b expected 1/1", rd_valid, busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({rd_valid, busy, axi_ar_valid, axi_r_ready} !== 4'b0000) begin errors++; $display("FAIL midrst_after: rd_valid/busy/ar_valid/r_ready got %b expected 0000", {rd_valid, busy, axi_ar_valid, axi_r_ready}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_legal_burst();
        test_error_resp();
        test_illegal_requests();
        test_early_last();
        test_credit_backpressure();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
